// File: rtl/light_package.sv
// light_package: shared light colors plus lane indexing for the intersection model.
package light_package;
    typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} colors;
    localparam int NUM_LANES = 5;
    localparam int LANE_ES = 0;
    localparam int LANE_WS = 1;
    localparam int LANE_EL = 2;
    localparam int LANE_WL = 3;
    localparam int LANE_NS = 4;
endpackage

// File: rtl/intersection_lane_model_lane_queue.sv
// lane_queue: saturating car queue for one lane, departing one car every DEPART_PERIOD green cycles.
module lane_queue
    import light_package::*;
#(
    parameter int MAX_CARS = 15,
    parameter int DEPART_PERIOD = 2,
    localparam int CW = $clog2(MAX_CARS + 1),
    localparam int GW = DEPART_PERIOD > 1 ? $clog2(DEPART_PERIOD) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_i,
    input  colors         light_i,
    output logic [CW-1:0] count_o,
    output logic          depart_o,
    output logic          depart_next_o,
    output logic          overflow_o
);
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          overflow_q, overflow_d, depart_q, green, due, dep_d;

    assign green = light_i == GREEN;
    assign due   = green && gap_q == GW'(DEPART_PERIOD - 1);
    assign dep_d = due && count_q != '0;
    assign gap_d = (!green || due) ? '0 : gap_q + 1'b1;

    // A simultaneous arrival and departure cancel out, so a full lane never overflows then.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (arrive_i && !dep_d) begin
            if (count_q == CW'(MAX_CARS)) overflow_d = 1'b1;
            else count_d = count_q + 1'b1;
        end else if (dep_d && !arrive_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            depart_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
            depart_q   <= dep_d;
        end
    end

    assign count_o       = count_q;
    assign depart_o      = depart_q;
    assign depart_next_o = dep_d;
    assign overflow_o    = overflow_q;
endmodule

// File: rtl/intersection_lane_model.sv
// intersection_lane_model: lane queues, sensors and light-legality monitor facing the traffic controller.
module intersection_lane_model
    import light_package::*;
#(
    parameter int MAX_CARS = 15,
    parameter int DEPART_PERIOD = 2,
    localparam int CW = $clog2(MAX_CARS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    arrive,
    input  colors         e_str_light,
    input  colors         w_str_light,
    input  colors         e_left_light,
    input  colors         w_left_light,
    input  colors         ns_light,
    output logic          e_str_sensor,
    output logic          w_str_sensor,
    output logic          e_left_sensor,
    output logic          w_left_sensor,
    output logic          ns_sensor,
    output logic [4:0]    depart,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1,
    output logic [CW-1:0] count2,
    output logic [CW-1:0] count3,
    output logic [CW-1:0] count4,
    output logic [4:0]    overflow,
    output logic          violation,
    output logic [7:0]    violation_count,
    output logic [15:0]   departed_total
);
    colors         lights [NUM_LANES];
    logic [CW-1:0] cnt [NUM_LANES];
    logic [4:0]    dep_next, nonred;
    logic          legal, violation_q;
    logic [7:0]    vcount_q;
    logic [15:0]   total_q;

    assign lights = '{e_str_light, w_str_light, e_left_light, w_left_light, ns_light};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_queue #(.MAX_CARS(MAX_CARS), .DEPART_PERIOD(DEPART_PERIOD)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .arrive_i     (arrive[i]),
            .light_i      (lights[i]),
            .count_o      (cnt[i]),
            .depart_o     (depart[i]),
            .depart_next_o(dep_next[i]),
            .overflow_o   (overflow[i])
        );
        assign nonred[i] = lights[i] != RED;
    end

    // Paired lanes must also agree on color, so a green/yellow split is caught.
    assign legal = nonred == 5'b00000 || nonred == 5'b10000
        || (nonred == 5'b00011 && lights[LANE_ES] == lights[LANE_WS])
        || (nonred == 5'b00101 && lights[LANE_ES] == lights[LANE_EL])
        || (nonred == 5'b01010 && lights[LANE_WS] == lights[LANE_WL])
        || (nonred == 5'b01100 && lights[LANE_EL] == lights[LANE_WL]);

    always_ff @(posedge clk) begin
        if (reset) begin
            violation_q <= 1'b0;
            vcount_q    <= '0;
            total_q     <= '0;
        end else begin
            violation_q <= violation_q | !legal;
            vcount_q    <= vcount_q + 8'(!legal && vcount_q != 8'hFF);
            total_q     <= total_q + 16'($countones(dep_next));
        end
    end

    assign {count0, count1, count2, count3, count4} = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]};
    assign e_str_sensor    = cnt[LANE_ES] != '0;
    assign w_str_sensor    = cnt[LANE_WS] != '0;
    assign e_left_sensor   = cnt[LANE_EL] != '0;
    assign w_left_sensor   = cnt[LANE_WL] != '0;
    assign ns_sensor       = cnt[LANE_NS] != '0;
    assign violation       = violation_q;
    assign violation_count = vcount_q;
    assign departed_total  = total_q;
endmodule

// File: tb/tb_intersection_lane_model.sv
// tb_intersection_lane_model: directed vectors against hand-computed queue, sensor and violation values.
module tb_intersection_lane_model;
    import light_package::*;
    logic        clk = 1'b0, reset = 1'b1;
    logic [4:0]  arrive = '0;
    colors       es = RED, ws = RED, el = RED, wl = RED, ns = RED;
    logic        es_s, ws_s, el_s, wl_s, ns_s, violation;
    logic [4:0]  depart, overflow;
    logic [3:0]  c0, c1, c2, c3, c4;
    logic [7:0]  vcount;
    logic [15:0] total;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    intersection_lane_model #(.MAX_CARS(15), .DEPART_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .arrive(arrive),
        .e_str_light(es), .w_str_light(ws), .e_left_light(el), .w_left_light(wl), .ns_light(ns),
        .e_str_sensor(es_s), .w_str_sensor(ws_s), .e_left_sensor(el_s), .w_left_sensor(wl_s),
        .ns_sensor(ns_s), .depart(depart), .count0(c0), .count1(c1), .count2(c2), .count3(c3),
        .count4(c4), .overflow(overflow), .violation(violation), .violation_count(vcount),
        .departed_total(total)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        check("reset_counts", {c0, c1, c2, c3, c4}, 0);
        check("reset_sensors", {es_s, ws_s, el_s, wl_s, ns_s}, 0);
        check("reset_flags", {depart, overflow, violation, vcount, total}, 0);

        arrive = 5'b00001;
        cyc(3);
        arrive = '0;
        check("arr_count0", c0, 3);
        check("arr_sensors", {es_s, ws_s, el_s, wl_s, ns_s}, 5'b10000);
        check("arr_depart", depart, 0);

        es = GREEN; ws = GREEN;
        cyc(); check("drain_a", {c0, 3'b0, depart}, {4'd3, 3'b0, 5'b00000});
        cyc(); check("drain_b", {c0, 3'b0, depart}, {4'd2, 3'b0, 5'b00001});
        cyc(); check("drain_c", {c0, 3'b0, depart}, {4'd2, 3'b0, 5'b00000});
        cyc(); check("drain_d", {c0, 3'b0, depart}, {4'd1, 3'b0, 5'b00000} | 1);
        cyc(); check("drain_e", {c0, 3'b0, depart}, {4'd1, 3'b0, 5'b00000});
        cyc(); check("drain_f", {c0, 3'b0, depart}, {4'd0, 3'b0, 5'b00001});
        check("drain_sensor", es_s, 0);
        check("drain_total", total, 3);
        cyc(); check("drain_empty_no_dep", depart, 0);
        check("drain_legal", violation, 0);
        es = RED; ws = RED;

        arrive = 5'b10000;
        cyc(15);
        arrive = '0;
        check("fill_count4", c4, 15);
        check("fill_no_ovf", overflow, 0);
        ns = GREEN;
        cyc();
        arrive = 5'b10000;
        cyc();
        check("arrdep_count4", c4, 15);
        check("arrdep_depart", depart, 5'b10000);
        check("arrdep_no_ovf", overflow, 0);
        ns = RED;
        cyc();
        arrive = '0;
        check("ovf_count4", c4, 15);
        check("ovf_flag", overflow, 5'b10000);
        check("ns_legal", violation, 0);

        es = GREEN; ns = GREEN;
        cyc();
        check("viol_first", {violation, vcount}, {1'b1, 8'd1});
        cyc();
        es = RED; ns = RED;
        check("viol_count", vcount, 2);
        cyc(2);
        check("viol_hold", {violation, vcount}, {1'b1, 8'd2});

        arrive = 5'b00100;
        cyc(5);
        arrive = '0;
        check("lane2_fill", c2, 5);
        el = GREEN; wl = YELLOW;
        cyc();
        check("mixed_pair_viol", vcount, 3);
        el = YELLOW;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("yellow_no_dep", {c2, depart}, {4'd5, 5'b00000});
        end
        check("yellow_legal", vcount, 3);

        el = GREEN; wl = GREEN;
        cyc(2);
        check("middrain_count2", c2, 4);
        reset = 1'b1;
        arrive = 5'b11111;
        cyc();
        reset = 1'b0;
        arrive = '0;
        el = RED; wl = RED;
        check("mid_reset_counts", {c0, c1, c2, c3, c4}, 0);
        check("mid_reset_sensors", {es_s, ws_s, el_s, wl_s, ns_s}, 0);
        check("mid_reset_flags", {depart, overflow, violation, vcount, total}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/intersection_lane_model.md
# intersection_lane_model

Cycle-accurate environment model for the 5-light traffic-light controller. It consumes the controller's light colors and per-lane car-arrival pulses, keeps a saturating car queue per lane, and drives the five traffic sensors back into the controller. It also departs cars on green and flags illegal light combinations. It sits on the opposite side of the sensor/light interface from the controller, in simulation and FPGA-demo top levels.

## Interface
Parameters:
- MAX_CARS, 15: queue capacity per lane (count width CW = $clog2(MAX_CARS+1)).
- DEPART_PERIOD, 2: cycles of green per departing car (≥1).

Ports (lane index: 0 e_str, 1 w_str, 2 e_left, 3 w_left, 4 ns):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- arrive  in  5  one car arrives at lane i this cycle (pulse).
- e_str_light, w_str_light, e_left_light, w_left_light, ns_light  in  colors  controller lights.
- e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor  out  1  lane queue non-empty.
- depart  out  5  car left lane i this cycle (registered pulse).
- count0..count4  out  CW  per-lane queue occupancy.
- overflow  out  5  sticky: arrival dropped at full lane i.
- violation  out  1  sticky: illegal light combination seen.
- violation_count  out  8  saturating count of illegal cycles.
- departed_total  out  16  wrapping count of all departures.

## Operation
- Per lane: count, gap counter (width $clog2(DEPART_PERIOD)), overflow flag.
- Gap counter: held at 0 while light ≠ green. While green: if gap == DEPART_PERIOD-1, reset to 0 and depart if count>0. Otherwise increment.
- Yellow and red: no departures. Cars never leave on yellow.
- Count update at each edge:
  - arrival only: +1 unless count==MAX_CARS. If full, count holds and overflow sets.
  - departure only: -1.
  - arrival and departure together: count unchanged, never overflows.
  - Departure cannot occur at count 0.
- sensor_i = (count_i != 0), driven from the registered count with no further logic.
- depart_i registered alongside count. departed_total += popcount(depart) per cycle, wrapping at 2^16.
- Legal non-red sets: {} , {e_str,w_str}, {e_str,e_left}, {w_str,w_left}, {e_left,w_left}, {ns}. Both members of a pair must show the same color.
- Any other non-red set, or a pair with mixed green/yellow, is illegal for that cycle. Illegal cycle → violation set (sticky), violation_count +1, saturating at 255.
- Light inputs are sampled once per cycle. The model never alters lights.

## Timing
- Reset values: all counts 0, sensors 0, depart 0, overflow 0, violation 0, violation_count 0, departed_total 0, gap counters 0.
- Reset mid-operation clears every queue and flag at the next edge. Arrivals in the reset cycle are discarded.
- Arrival at cycle t → count and sensor high from cycle t+1.
- Light green first sampled at edge t → first departure edge at t+DEPART_PERIOD-1, then one departure every DEPART_PERIOD edges.
- DEPART_PERIOD=1: one departure per green cycle.
- Green→yellow: the gap counter clears at the next edge. A departure due on that same edge is suppressed.
- Violation is flagged at the edge after the illegal combination is present.

## Structure
- Extend the shared light_package with lane index constants (LANE_ES=0 … LANE_NS=4) and NUM_LANES=5. The colors enum stays there unchanged.
- One sub-module, lane_queue: count, gap counter, overflow, depart for a single lane. Instantiate it 5× from a colors array built from the five light inputs.
- Light legality check and totals live in the top module.

## Test plan
- Reset, all lights red, arrive=5'b00001 for 3 cycles → count0=3, e_str_sensor=1, other sensors 0, depart 0.
- count0=3, e_str/w_str green, DEPART_PERIOD=2 → depart0 pulses every 2nd cycle. count0 3→2→1→0, sensor drops after the third departure, departed_total=3.
- Lane 4 at MAX_CARS=15 with arrive[4] asserted → count4 stays 15, overflow[4]=1. Arrival plus departure together at 15 → count4 stays 15, no new overflow.
- e_str green and ns green together for 2 cycles → violation=1, violation_count=2. Lights return legal → count holds at 2.
- e_left green, w_left yellow → violation. e_left/w_left both yellow → legal, and no departures occur.
- Assert reset mid-drain with count2=5 → next cycle all counts 0, sensors 0, flags cleared.
